// File: rtl/ecc_scrub_pkg.sv
// ecc_scrub_pkg
//   Shared definitions for the SEC-DED background scrubber: the FSM state
//   encoding and its width. Imported by ecc_secded_scrubber.
//   No ports.
package ecc_scrub_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    READ,
    WAIT,
    CHECK,
    WB,
    NEXT,
    DONE,
    GAP
  } scrub_state_t;

endpackage

// File: rtl/ecc_scrub_port_mux.sv
// ecc_scrub_port_mux
//   Combinational arbitration of the single memory port between the host and
//   the scrubber. A host write always owns the port. With no host write, an
//   active scrubber drives the port; an idle scrubber leaves the address on the
//   host so the host can read through the decoder.
// Ports
//   host_wr_en/host_addr/host_data   host request
//   scrub_active                     scrubber FSM not idle
//   scrub_addr/scrub_wr_en/scrub_wdata  scrubber request
//   mem_addr/mem_wr_en/mem_wdata     memory/encoder port
module ecc_scrub_port_mux #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              scrub_active,
  input  logic [ADDR_W-1:0] scrub_addr,
  input  logic              scrub_wr_en,
  input  logic [DATA_W-1:0] scrub_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata
);

  always_comb begin
    // NOTE: every output gets a default before any condition, so no path
    // leaves a value unassigned and no latch is inferred.
    mem_addr  = host_addr;
    mem_wr_en = host_wr_en;
    mem_wdata = host_data;
    if (!host_wr_en && scrub_active) begin
      mem_addr  = scrub_addr;
      mem_wr_en = scrub_wr_en;
      mem_wdata = scrub_wdata;
    end
  end

endmodule

// File: rtl/ecc_secded_scrubber.sv
// ecc_secded_scrubber
//   Background scrubber in front of a SEC-DED protected memory. Walks
//   addresses 0..DEPTH-1, reads each word through the decoder, writes back the
//   corrected byte on a single-bit error, and logs double-bit errors without
//   touching the word. Host writes share the memory port and always win; a
//   word being scrubbed when a host write arrives is restarted from READ.
// Ports
//   clk, rst (async, active low)
//   start, continuous, interval        pass control
//   host_wr_en, host_addr, host_data   host port
//   mem_addr, mem_wr_en, mem_wdata     memory/encoder port
//   dec_data, dec_sec, dec_ded         decoder results
//   busy, done                         pass status
//   sec_count, ded_count, last_ded_addr  statistics
//   ded_irq                            sticky DED flag, cleared by start
// Configuration
//   ECC_SCRUB_STATS_EN: when defined, sec_count/ded_count/last_ded_addr are
//   live; otherwise they read 0 and their flops are not built.
module ecc_secded_scrubber
  import ecc_scrub_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int CNT_W      = 8,
  parameter int INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [INTERVAL_W-1:0] interval,
  input  logic                  host_wr_en,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_data,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     dec_data,
  input  logic                  dec_sec,
  input  logic                  dec_ded,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      sec_count,
  output logic [CNT_W-1:0]      ded_count,
  output logic [ADDR_W-1:0]     last_ded_addr,
  output logic                  ded_irq
);

  localparam int                WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  scrub_state_t          state, state_nx;
  logic [ADDR_W-1:0]     addr;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [INTERVAL_W-1:0] gap_cnt;
  logic [DATA_W-1:0]     cap_data;
  logic                  ded_irq_q;

  // Accepted start and a DED observed in CHECK with the port not stolen.
  logic start_ok;
  logic ev_ded;

  assign start_ok = (state == IDLE) && start;
  assign ev_ded   = (state == CHECK) && !host_wr_en && dec_ded;

  // Next-state logic. A host write during READ/WAIT/CHECK/WB drops the word
  // back to READ, and READ holds while the host still owns the port, so the
  // re-read starts the cycle after host_wr_en falls.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = READ;
      READ:  if (!host_wr_en) state_nx = WAIT;
      WAIT: begin
        if (host_wr_en)             state_nx = READ;
        else if (wait_cnt == '0)    state_nx = CHECK;
      end
      CHECK: begin
        if (host_wr_en)             state_nx = READ;
        else if (dec_ded)           state_nx = NEXT;
        else if (dec_sec)           state_nx = WB;
        else                        state_nx = NEXT;
      end
      WB:    state_nx = host_wr_en ? READ : NEXT;
      NEXT:  state_nx = (addr == LAST_ADDR) ? DONE : READ;
      DONE: begin
        if (!continuous)            state_nx = IDLE;
        else if (interval == '0)    state_nx = READ;
        else                        state_nx = GAP;
      end
      GAP:   if (gap_cnt == '0) state_nx = READ;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      cap_data  <= '0;
      ded_irq_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // in this block sees the pre-edge values of the others.
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          addr      <= '0;
          ded_irq_q <= 1'b0;
        end
        READ:  wait_cnt <= WAIT_W'(RD_LAT - 1);
        WAIT:  if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        CHECK: if (!host_wr_en) begin
          cap_data <= dec_data;
          if (dec_ded) ded_irq_q <= 1'b1;
        end
        NEXT:  addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        // GAP lasts exactly 'interval' cycles, so preload one less.
        DONE:  if (continuous && interval != '0) gap_cnt <= interval - 1'b1;
        GAP:   if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign ded_irq = ded_irq_q;

`ifdef ECC_SCRUB_STATS_EN
  // SEC is counted only when the writeback cycle actually owned the port.
  logic              ev_sec;
  logic [CNT_W-1:0]  sec_q, ded_q;
  logic [ADDR_W-1:0] last_q;

  assign ev_sec = (state == WB) && !host_wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q  <= '0;
      ded_q  <= '0;
      last_q <= '0;
    end else if (start_ok) begin
      sec_q <= '0;
      ded_q <= '0;
    end else begin
      if (ev_sec && sec_q != '1) sec_q <= sec_q + 1'b1;
      if (ev_ded) begin
        if (ded_q != '1) ded_q <= ded_q + 1'b1;
        last_q <= addr;
      end
    end
  end

  assign sec_count     = sec_q;
  assign ded_count     = ded_q;
  assign last_ded_addr = last_q;
`else
  assign sec_count     = '0;
  assign ded_count     = '0;
  assign last_ded_addr = '0;
`endif

  ecc_scrub_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_port_mux (
    .host_wr_en  (host_wr_en),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .scrub_active(busy),
    .scrub_addr  (addr),
    .scrub_wr_en (state == WB),
    .scrub_wdata (cap_data),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wdata   (mem_wdata)
  );

endmodule
